list_reduce_engine: RTL and testbench
=====================================

// Module: list_reduce_engine
// PURPOSE
//  Parametrised successor of the linked-list sum controller: FSM plus datapath that walks a
//  singly linked list in node memory, starting at head_addr, and reduces node values.
//  Reductions: sum, max, min or count. Handles variable memory read latency and guards
//  against cyclic lists with a node limit. Sits between the host start/done handshake
//  and the node memory port.
// PARAMETERS
//  DW        16   node value / result width (bits)
//  AW        8    node address width; address 0 is the null (end-of-list) pointer
//  MAX_NODES 255  traversal limit before timeout; 1..2**CW-1
//  CW        8    node counter width
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, synchronous, active-high
//  start      in   1   level request; sampled only in IDLE and DONE
//  mode       in   2   0=sum 1=max(unsigned) 2=min(unsigned) 3=count; latched on start
//  head_addr  in   AW  first node address; latched on start
//  mem_req    out  1   one-cycle read strobe
//  mem_addr   out  AW  read address, valid while mem_req=1
//  mem_rvalid in   1   read data valid (>=1 cycle after mem_req)
//  mem_val    in   DW  node value, qualified by mem_rvalid
//  mem_next   in   AW  node next pointer, qualified by mem_rvalid
//  result     out  DW  reduction result, stable while done=1
//  node_count out  CW  nodes visited
//  busy       out  1   high in REQ/WAIT/ACC
//  done       out  1   high in DONE only
//  overflow   out  1   sticky: sum wrapped (mode 0 only)
//  timeout    out  1   MAX_NODES reached with non-null next pointer
// BEHAVIOUR
//  Reset: state=IDLE; mem_req, done, busy, overflow, timeout = 0; result, node_count = 0;
//   mem_addr = 0. Reset mid-walk aborts immediately. A later mem_rvalid is ignored.
//  States: IDLE, REQ, WAIT, ACC, DONE (registered state; outputs decoded from state).
//  IDLE: start=1 -> latch mode/head_addr; clear result/count/flags.
//   head_addr==0 -> DONE (result 0, count 0); else -> REQ.
//   Result init: sum/count=0, max=0, min=all-ones.
//  REQ: mem_req=1, mem_addr=cur_addr for exactly one cycle -> WAIT.
//  WAIT: hold until mem_rvalid=1; capture mem_val/mem_next -> ACC.
//   mem_rvalid in any other state is ignored.
//  ACC: node_count+=1; update result per mode.
//   Sum wraps mod 2**DW; carry-out sets overflow.
//   Count mode: result = zero-extended node_count (new value).
//   next==0 -> DONE.
//   else node_count==MAX_NODES (after increment) -> timeout=1, DONE.
//   else cur_addr<=next -> REQ.
//  Per-node cost: 3 cycles + memory latency beyond 1.
//  DONE: done=1, outputs frozen. start=0 -> IDLE (flags kept until next start).
//   start held high -> remain in DONE; no restart without a low level.
//  start changes while busy are ignored. mode/head_addr changes after latch are ignored.
//  Self-loop (next==own addr) terminates via timeout, never hangs.
// STRUCTURE
//  Shared package list_pkg: state encoding localparams, MODE_SUM/MAX/MIN/CNT, NULL_ADDR.
//  Sub-module list_reduce_alu (combinational): mode, acc, val -> new_acc, carry.
//  Top holds FSM, address/counter registers and flags.
// TESTING
//  1. 3-node list at 5->9->2 (vals 10,20,30), mode 0, 1-cycle mem
//     -> result=60, count=3, done, no flags.
//  2. Same list, mode 1 / mode 2 / mode 3 -> result 30 / 10 / 3.
//  3. head_addr=0 -> done the cycle after start, result=0, count=0, no mem_req.
//  4. DW=8, vals 200,100, mode 0 -> result=44, overflow=1.
//  5. Self-loop node 4->4, MAX_NODES=5 -> timeout=1, count=5, done.
//  6. Random 0-4 cycle rvalid delay plus rst asserted in WAIT
//     -> IDLE next cycle, all outputs 0. Late rvalid ignored. Restart gives correct sum.

Source files
------------

// File: rtl/list_pkg.sv
// Shared encodings for the linked-list reduction engine: FSM states, reduction modes, null pointer.
package list_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] MODE_SUM = 2'd0;
  localparam logic [1:0] MODE_MAX = 2'd1;
  localparam logic [1:0] MODE_MIN = 2'd2;
  localparam logic [1:0] MODE_CNT = 2'd3;

  localparam int NULL_ADDR = 0;
endpackage

// File: rtl/list_reduce_alu.sv
// Combinational reduction step: folds one node value into the running accumulator.
module list_reduce_alu
  import list_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [1:0]    i_mode,
  input  logic [DW-1:0] i_acc,
  input  logic [DW-1:0] i_val,
  output logic [DW-1:0] o_new_acc,
  output logic          o_carry
);
  logic [DW:0] w_sum;

  assign w_sum = {1'b0, i_acc} + {1'b0, i_val};

  // Count mode is resolved in the top from the node counter; acc passes through here.
  always_comb begin
    o_new_acc = i_acc;
    o_carry   = 1'b0;
    case (i_mode)
      MODE_SUM: begin
        o_new_acc = w_sum[DW-1:0];
        o_carry   = w_sum[DW];
      end
      MODE_MAX: if (i_val > i_acc) o_new_acc = i_val;
      MODE_MIN: if (i_val < i_acc) o_new_acc = i_val;
      default:  o_new_acc = i_acc;
    endcase
  end
endmodule

// File: rtl/list_reduce_engine.sv
// Walks a singly linked list in node memory from head_addr and reduces node values
// (sum/max/min/count), with a node limit that breaks cyclic lists.
module list_reduce_engine
  import list_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = 8,
  parameter int MAX_NODES = 255,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] head_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_val,
  input  logic [AW-1:0] mem_next,
  output logic [DW-1:0] result,
  output logic [CW-1:0] node_count,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic          timeout
);
  state_t        r_state, w_state_nxt;
  logic [1:0]    r_mode;
  logic [AW-1:0] r_cur, r_next;
  logic [DW-1:0] r_val, r_result;
  logic [CW-1:0] r_count;
  logic          r_ovf, r_tmo;

  logic [DW-1:0] w_alu_acc;
  logic          w_alu_carry;
  logic [CW-1:0] w_cnt_inc;
  logic          w_next_null, w_limit, w_head_null;

  assign w_cnt_inc   = r_count + 1'b1;
  assign w_next_null = (r_next == AW'(NULL_ADDR));
  assign w_head_null = (head_addr == AW'(NULL_ADDR));
  assign w_limit     = (w_cnt_inc == CW'(MAX_NODES));

  list_reduce_alu #(.DW(DW)) u_alu (
    .i_mode    (r_mode),
    .i_acc     (r_result),
    .i_val     (r_val),
    .o_new_acc (w_alu_acc),
    .o_carry   (w_alu_carry)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = w_head_null ? S_DONE : S_REQ;
      S_REQ:  w_state_nxt = S_WAIT;
      S_WAIT: if (mem_rvalid) w_state_nxt = S_ACC;
      S_ACC:  w_state_nxt = (w_next_null || w_limit) ? S_DONE : S_REQ;
      S_DONE: if (!start) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mode   <= MODE_SUM;
      r_cur    <= '0;
      r_next   <= '0;
      r_val    <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (start) begin
          r_mode   <= mode;
          r_cur    <= head_addr;
          r_count  <= '0;
          r_ovf    <= 1'b0;
          r_tmo    <= 1'b0;
          // An empty list reports 0 even in min mode.
          r_result <= (mode == MODE_MIN && !w_head_null) ? '1 : '0;
        end
        S_WAIT: if (mem_rvalid) begin
          r_val  <= mem_val;
          r_next <= mem_next;
        end
        S_ACC: begin
          r_count  <= w_cnt_inc;
          r_result <= (r_mode == MODE_CNT) ? DW'(w_cnt_inc) : w_alu_acc;
          if (r_mode == MODE_SUM && w_alu_carry) r_ovf <= 1'b1;
          if (!w_next_null && w_limit) r_tmo <= 1'b1;
          if (!w_next_null && !w_limit) r_cur <= r_next;
        end
        default: ;
      endcase
    end
  end

  assign mem_req    = (r_state == S_REQ);
  assign mem_addr   = r_cur;
  assign result     = r_result;
  assign node_count = r_count;
  assign busy       = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_ACC);
  assign done       = (r_state == S_DONE);
  assign overflow   = r_ovf;
  assign timeout    = r_tmo;
endmodule

// File: tb/tb_list_reduce_engine.sv
// Directed bench for list_reduce_engine with a latency-programmable node memory model.
module tb_list_reduce_engine;
  localparam int DW = 8, AW = 8, CW = 8, MAXN = 5;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] head_addr = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_val = '0;
  logic [AW-1:0] mem_next = '0;
  logic [DW-1:0] result;
  logic [CW-1:0] node_count;
  logic          busy, done, overflow, timeout;

  int vectors = 0, miscmp = 0, req_cnt = 0, lat_fix = 0;
  bit lat_rand = 1'b0;
  logic [DW-1:0] mv [256];
  logic [AW-1:0] mn [256];

  always #5 clk = ~clk;

  list_reduce_engine #(.DW(DW), .AW(AW), .MAX_NODES(MAXN), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .head_addr(head_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
    .mem_val(mem_val), .mem_next(mem_next), .result(result), .node_count(node_count),
    .busy(busy), .done(done), .overflow(overflow), .timeout(timeout)
  );

  // Node memory: answers each mem_req with a one-cycle rvalid 1+lat cycles later.
  initial begin : responder
    bit pend;
    int cnt;
    logic [AW-1:0] a;
    pend = 1'b0; cnt = 0; a = '0;
    forever begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          mem_rvalid = 1'b1; mem_val = mv[a]; mem_next = mn[a]; pend = 1'b0;
        end else cnt--;
      end
      if (mem_req) begin
        pend = 1'b1; a = mem_addr; req_cnt++;
        cnt = lat_rand ? int'($urandom_range(0, 4)) : lat_fix;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic walk(input logic [1:0] m, input logic [AW-1:0] h, input bit scramble,
                      output int cyc);
    @(negedge clk); mode = m; head_addr = h; start = 1'b1; cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (cyc == 1 && h != 0) chk("busy_first", busy, 1);
      if (scramble) begin mode = ~m; head_addr = '0; end
    end while (!done && cyc < 300);
    chk("done_seen", done, 1);
  endtask

  task automatic release_start();
    start = 1'b0;
    @(negedge clk);
    chk("rel_done", done, 0);
    chk("rel_busy", busy, 0);
  endtask

  initial begin
    int cyc, r0, n;
    for (int i = 0; i < 256; i++) begin mv[i] = '0; mn[i] = '0; end
    mv[5] = 8'd10; mn[5] = 8'd9;
    mv[9] = 8'd20; mn[9] = 8'd2;
    mv[2] = 8'd30; mn[2] = 8'd0;
    mv[6] = 8'd200; mn[6] = 8'd7;
    mv[7] = 8'd100; mn[7] = 8'd0;
    mv[4] = 8'd1;  mn[4] = 8'd4;
    mv[3] = 8'd7;  mn[3] = 8'd8;
    mv[8] = 8'd11; mn[8] = 8'd11;
    mv[11] = 8'd13; mn[11] = 8'd0;

    repeat (2) @(negedge clk);
    chk("rst_done", done, 0);       chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);     chk("rst_addr", mem_addr, 0);
    chk("rst_result", result, 0);   chk("rst_count", node_count, 0);
    chk("rst_ovf", overflow, 0);    chk("rst_tmo", timeout, 0);
    rst = 1'b0;

    // 3-node sum, 1-cycle memory: 1 + 3*3 cycles to DONE
    walk(2'd0, 8'd5, 1'b0, cyc);
    chk("sum_result", result, 60);  chk("sum_count", node_count, 3);
    chk("sum_ovf", overflow, 0);    chk("sum_tmo", timeout, 0);
    chk("sum_latency", cyc, 10);
    @(negedge clk);
    chk("hold_done", done, 1);      chk("hold_result", result, 60);
    release_start();

    // max with mode/head scrambled after latch; min; count
    walk(2'd1, 8'd5, 1'b1, cyc);
    chk("max_result", result, 30);
    release_start();
    walk(2'd2, 8'd5, 1'b0, cyc);
    chk("min_result", result, 10);
    release_start();
    walk(2'd3, 8'd5, 1'b0, cyc);
    chk("cnt_result", result, 3);   chk("cnt_count", node_count, 3);
    release_start();

    // empty list
    r0 = req_cnt;
    walk(2'd2, 8'd0, 1'b0, cyc);
    chk("null_latency", cyc, 1);    chk("null_result", result, 0);
    chk("null_count", node_count, 0); chk("null_noreq", req_cnt - r0, 0);
    release_start();

    // 8-bit sum wrap: 200+100 = 300 -> 44
    walk(2'd0, 8'd6, 1'b0, cyc);
    chk("wrap_result", result, 44); chk("wrap_ovf", overflow, 1);
    chk("wrap_count", node_count, 2);
    release_start();
    chk("ovf_kept", overflow, 1);

    // self-loop stopped by node limit
    walk(2'd0, 8'd4, 1'b0, cyc);
    chk("loop_tmo", timeout, 1);    chk("loop_count", node_count, 5);
    chk("loop_result", result, 5);  chk("loop_ovf", overflow, 0);
    release_start();
    chk("tmo_kept", timeout, 1);

    // reset while waiting on the second node, then a late rvalid arrives
    lat_fix = 4;
    @(negedge clk); mode = 2'd0; head_addr = 8'd3; start = 1'b1;
    r0 = req_cnt; n = 0;
    while (req_cnt < r0 + 2 && n < 200) begin @(negedge clk); n++; end
    chk("second_req_seen", req_cnt - r0, 2);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);   chk("pre_rst_result", result, 7);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("arst_busy", busy, 0);      chk("arst_done", done, 0);
    chk("arst_req", mem_req, 0);    chk("arst_addr", mem_addr, 0);
    chk("arst_result", result, 0);  chk("arst_count", node_count, 0);
    chk("arst_tmo", timeout, 0);    chk("arst_ovf", overflow, 0);
    repeat (8) @(negedge clk);
    chk("late_busy", busy, 0);      chk("late_result", result, 0);
    chk("late_count", node_count, 0);

    lat_rand = 1'b1;
    walk(2'd0, 8'd3, 1'b0, cyc);
    chk("rand_result", result, 31); chk("rand_count", node_count, 3);
    chk("rand_tmo", timeout, 0);
    release_start();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end
endmodule
